muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer and HI/LO register owner for the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EXE stage and runs a radix-2 shift-add multiply or restoring divide.
- Writes HI/LO and raises a stall request, which the hazard logic ORs into its own stall/flush outputs, while HI/LO-dependent instructions must wait.
- Also handles MTHI/MTLO writes and qualifies MFHI/MFLO reads.

---
 rtl/muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide sequencer that owns the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are all zero.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             md_stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       op_q;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] orig_a;

    logic             is_div;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic             last_iter;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_div    = op_q[1];
    assign in_sign_a = ~op[0] & src_a[WIDTH-1];
    assign in_sign_b = ~op[0] & src_b[WIDTH-1];
    assign abs_a     = in_sign_a ? -src_a : src_a;
    assign abs_b     = in_sign_b ? -src_b : src_b;
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign md_stall  = busy & (start | hilo_we | rd_req);

    // acc_hi:acc_lo is the product (multiply) or remainder:dividend/quotient (divide)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        // low (WIDTH-cnt-1) bits of nxt_lo are the multiplier bits not yet consumed
        if (!is_div && ((nxt_lo & ({WIDTH{1'b1}} >> cnt_nxt)) == '0))
            last_iter = 1'b1;
`endif
    end

    always_comb begin
        prod = {acc_hi, acc_lo};
`ifdef MULDIV_EARLY_OUT_EN
        prod = prod >> (CNT_W'(WIDTH) - cnt);
`endif
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix  = sign_a ? -acc_hi : acc_hi;
        if (!is_div) begin
            {fix_hi, fix_lo} = prod_fix;
        end else if (div_zero) begin
            fix_hi = orig_a;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        div_zero <= op[1] & (src_b == '0);
                        orig_a   <= src_a;
                        acc_hi   <= '0;
                        acc_lo   <= op[1] ? abs_a : abs_b;
                        opnd     <= op[1] ? abs_b : abs_a;
                        cnt      <= '0;
                        state    <= CALC;
                        busy     <= 1'b1;
                    end else if (hilo_we) begin
                        if (hilo_sel) hi <= wdata;
                        else          lo <= wdata;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt_nxt;
                        if (last_iter) begin
                            state <= FIX;
                            done  <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (!cancel) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed literal cases plus randomized traffic vs. an arithmetic model.
// Honors MULDIV_EARLY_OUT_EN for multiply latency expectations.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         hilo_we = 1'b0;
    logic         hilo_sel = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         rd_req = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         md_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata), .rd_req(rd_req), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .md_stall(md_stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {hi, lo} straight from integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, sq, sr;
        logic [63:0]  ua, ub, uq, ur, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            default: begin
                if (b == '0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p  = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Number of CALC cycles an operation spends
    function automatic int calc_len(input logic [1:0] o, input logic [W-1:0] b);
        logic [W-1:0] m;
        int n;
        if (!EARLY || o[1]) return W;
        m = (!o[0] && b[W-1]) ? -b : b;
        n = 1;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    logic         m_valid = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_fix = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [63:0]  m_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_fix   <= 1'b0;
            m_left  <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
        end else if (m_busy && cancel) begin
            m_busy <= 1'b0;
            m_fix  <= 1'b0;
        end else if (m_fix) begin
            m_busy <= 1'b0;
            m_fix  <= 1'b0;
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_fix <= 1'b1;
        end else if (start) begin
            m_busy <= 1'b1;
            m_left <= calc_len(op, src_b);
            m_res  <= ref_result(op, src_a, src_b);
        end else if (hilo_we) begin
            if (hilo_sel) m_hi <= wdata;
            else          m_lo <= wdata;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", busy, m_busy);
            check("done", done, m_fix);
            check("md_stall", md_stall, m_busy & (start | hilo_we | rd_req));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (start && hilo_we && !busy) begin
                errors++;
                $display("FAIL illegal_start_with_hilo_we at %0t", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_n, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, exp_n);
        tick();
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        check({name, "_idle"}, busy, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 255));
            5: return -W'($urandom_range(1, 16));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_done;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        rd_req = 1'b1;
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_stall", md_stall, 0);
        rd_req = 1'b0;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7, EARLY ? 3 : 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32, 32'h0000_0005, 32'hFFFF_FFFF);
        run_op("div_wrap",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0, 32'h8000_0000);
        run_op("multu_eo",  2'b01, 32'h1234, 32'h3, EARLY ? 2 : 32, 32'h0, 32'h0000_369C);

        // Stall window with rd_req held, plus an ignored second start
        op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        rd_req = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            if (i == 5) start = 1'b1;
            #1;
            check("stall_window", md_stall, 1);
            tick();
            start = 1'b0;
        end
        #1;
        check("stall_release", md_stall, 0);
        check("stall_busy_clear", busy, 0);
        check("stall_lo", lo, 32'd333);
        check("stall_hi", hi, 32'd1);
        rd_req = 1'b0;
        tick();

        // MTLO then a cancelled MULTU
        hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h1234_5678;
        tick();
        hilo_we = 1'b0;
        check("mtlo_lo", lo, 32'h1234_5678);
        op = 2'b01; src_a = 32'd99; src_b = 32'hFFFF_0001; start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_lo", lo, 32'h1234_5678);
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("cancel_no_done", saw_done, 0);

        // Reset in the middle of a divide
        op = 2'b10; src_a = 32'd12345; src_b = 32'd17; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_req = 1'b1;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_stall", md_stall, 0);
        rd_req = 1'b0;
        tick();
        run_op("after_rst_div", 2'b10, 32'd100, 32'd7, 32, 32'd2, 32'd14);

        // Randomized traffic, checked every cycle by the model
        repeat (4000) begin
            start    = ($urandom_range(0, 9) == 0);
            hilo_we  = !start && ($urandom_range(0, 7) == 0);
            hilo_sel = $urandom_range(0, 1) == 1;
            wdata    = $urandom;
            rd_req   = ($urandom_range(0, 3) == 0);
            cancel   = ($urandom_range(0, 79) == 0);
            op       = 2'($urandom_range(0, 3));
            src_a    = pick();
            src_b    = pick();
            tick();
        end
        start = 1'b0; hilo_we = 1'b0; rd_req = 1'b0; cancel = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
